// File: rtl/adder_arb_pkg.sv
// Shared constants and width helpers for the shared-adder arbiter slice.
package adder_arb_pkg;

   // Default configuration: four requesters, 7-bit operands, strobe every 2 clocks.
   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF  = 7;
   localparam int DIV_DEF     = 2;
   localparam int SUM_W_DEF   = DATA_W_DEF + 1;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Sum width: one carry bit above the operand width, so A+B never wraps.
   function automatic int sum_w(input int data_w);
      return data_w + 1;
   endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Round-robin grant logic with its priority pointer. The pointer holds the
// index of the last requester granted; the search starts one above it.
module rr_arbiter
   import adder_arb_pkg::*;
#(
   parameter int N = NUM_REQ_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req,
   input  logic                  en,
   input  logic                  ptr_upd,
   output logic [N-1:0]          gnt,
   output logic [id_w(N)-1:0]    gnt_idx
);

   localparam int IW = id_w(N);

   logic [IW-1:0] rr_ptr;
   int            cand;

   // Pick the first requester above rr_ptr, wrapping modulo N.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
      gnt     = '0;
      gnt_idx = '0;
      cand    = 0;
      if (en) begin
         // Walk from the farthest candidate to the nearest; the last hit wins,
         // so the nearest requester above rr_ptr ends up granted.
         for (int k = N; k >= 1; k--) begin
            cand = (int'(rr_ptr) + k) % N;
            if (req[cand]) begin
               gnt       = '0;
               gnt[cand] = 1'b1;
               gnt_idx   = IW'(cand);
            end
         end
      end
   end

   // Pointer moves only when a grant is actually taken.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst)
         rr_ptr <= IW'(N - 1);
      else if (ptr_upd)
         rr_ptr <= gnt_idx;
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// One registered adder shared by NUM_REQ requesters. A free-running divider
// produces an issue strobe every DIV clocks; on a strobe with the result slot
// free, the round-robin arbiter grants one requester and its A+B is
// registered together with its ID on a valid/ready response port.
module adder_share_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DIV     = DIV_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]     req_a,
   input  logic [NUM_REQ*DATA_W-1:0]     req_b,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [id_w(NUM_REQ)-1:0]      rsp_id,
   output logic [DATA_W:0]               rsp_sum,
   output logic                          busy
);

   localparam int ID_W  = id_w(NUM_REQ);
   localparam int SUM_W = sum_w(DATA_W);
   localparam int DCW   = (DIV > 1) ? $clog2(DIV) : 1;

   logic [DCW-1:0]     div_cnt;
   logic               tick;
   logic               slot_free;
   logic               grant_en;
   logic               accept;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic [DATA_W-1:0]  a_sel;
   logic [DATA_W-1:0]  b_sel;

   // The strobe fires on the last count of each DIV-cycle period; with DIV=1
   // the counter stays at 0 and the strobe is constant.
   assign tick      = (div_cnt == DCW'(DIV - 1));
   // A held result may drain in the same cycle a new one is loaded.
   assign slot_free = !rsp_valid || rsp_ready;
   // Reset gates the grant so no handshake completes while rst is high.
   assign grant_en  = !rst && tick && slot_free;
   assign accept    = |gnt;
   assign req_ready = gnt;
   assign busy      = rsp_valid;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .en      (grant_en),
      .ptr_upd (accept),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Select the granted requester's operands from the packed buses.
   always_comb begin
      a_sel = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
      b_sel = req_b[int'(gnt_idx)*DATA_W +: DATA_W];
   end

   // Free-running issue divider, independent of traffic.
   always_ff @(posedge clk) begin
      if (rst || tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DCW'(1);
   end

   // Result register: load on accept, drop valid on a drain with no refill.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_id    <= gnt_idx;
         rsp_sum   <= SUM_W'(a_sel) + SUM_W'(b_sel);
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Table-driven bench for adder_share_arbiter at the default configuration
// (4 requesters, 7-bit operands, DIV=2). Each row is one clock cycle.
module tb_adder_share_arbiter;

   localparam int NR = 4;
   localparam int DW = 7;

   typedef struct {
      logic          rst;
      logic [NR-1:0] valid;
      logic          rdy;
      logic [NR-1:0] exp_rdy;
      logic          exp_v;
      logic          chk;
      logic [1:0]    exp_id;
      logic [7:0]    exp_sum;
   } vec_t;

   typedef struct {
      logic [1:0] id;
      logic [7:0] sum;
   } sb_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*DW-1:0] req_a;
   logic [NR*DW-1:0] req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_id;
   logic [DW:0]      rsp_sum;
   logic             busy;

   logic [DW-1:0] tb_a [NR];
   logic [DW-1:0] tb_b [NR];

   vec_t tbl[$];
   sb_t  sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         req_a[i*DW +: DW] = tb_a[i];
         req_b[i*DW +: DW] = tb_b[i];
      end
   end

   adder_share_arbiter #(
      .NUM_REQ (NR),
      .DATA_W  (DW),
      .DIV     (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int oh_idx(input logic [NR-1:0] v);
      int r = 0;
      for (int i = 0; i < NR; i++)
         if (v[i]) r = i;
      return r;
   endfunction

   task automatic add(input logic r, input logic [NR-1:0] v, input logic rd,
                      input logic [NR-1:0] er, input logic ev, input logic c,
                      input logic [1:0] id, input logic [7:0] s);
      vec_t e;
      e.rst = r; e.valid = v; e.rdy = rd; e.exp_rdy = er;
      e.exp_v = ev; e.chk = c; e.exp_id = id; e.exp_sum = s;
      tbl.push_back(e);
   endtask

   // Drive one row at the falling edge, then compare after inputs settle.
   task automatic apply(input vec_t v);
      sb_t exp_e;
      sb_t got;
      int  gi;
      @(negedge clk);
      rst       = v.rst;
      req_valid = v.valid;
      rsp_ready = v.rdy;
      if (v.rst) sb_q.delete();
      #1;
      check("req_ready", 32'(req_ready), 32'(v.exp_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(v.exp_v));
      check("busy",      32'(busy),      32'(v.exp_v));
      if (v.chk) begin
         check("rsp_id",  32'(rsp_id),  32'(v.exp_id));
         check("rsp_sum", 32'(rsp_sum), 32'(v.exp_sum));
      end
      // Response handshake completes at the next edge: pop and compare.
      if (!v.rst && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got id=%0d sum=%0d, expected no response", rsp_id, rsp_sum);
         end else begin
            got.id  = rsp_id;
            got.sum = rsp_sum;
            exp_e   = sb_q.pop_front();
            check("sb_id",  32'(got.id),  32'(exp_e.id));
            check("sb_sum", 32'(got.sum), 32'(exp_e.sum));
         end
      end
      // Grant expected this cycle: queue the result it must produce.
      if (!v.rst && v.exp_rdy != '0) begin
         gi        = oh_idx(v.exp_rdy);
         exp_e.id  = 2'(gi);
         exp_e.sum = {1'b0, tb_a[gi]} + {1'b0, tb_b[gi]};
         sb_q.push_back(exp_e);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t hv;
      tb_a[0] = 7'd100; tb_b[0] = 7'd27;   // 127
      tb_a[1] = 7'd127; tb_b[1] = 7'd127;  // 254, max operands
      tb_a[2] = 7'd5;   tb_b[2] = 7'd9;    // 14
      tb_a[3] = 7'd60;  tb_b[3] = 7'd3;    // 63
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
      repeat (2) @(posedge clk);

      //  rst valid   rdy exp_rdy ev chk id  sum      (ticks on odd cycles after release)
      add(1, 4'b0000, 1, 4'b0000, 0, 1, 0, 8'd0);   // reset, idle
      add(1, 4'b0000, 1, 4'b0000, 0, 1, 0, 8'd0);
      add(1, 4'b0000, 1, 4'b0000, 0, 1, 0, 8'd0);
      add(0, 4'b0000, 1, 4'b0000, 0, 1, 0, 8'd0);   // released, no tick
      add(0, 4'b0001, 1, 4'b0001, 0, 0, 0, 8'd0);   // tick: single request 0
      add(0, 4'b0000, 1, 4'b0000, 1, 1, 0, 8'd127);
      add(0, 4'b0010, 1, 4'b0010, 0, 0, 0, 8'd0);   // tick: max operands
      add(0, 4'b0000, 1, 4'b0000, 1, 1, 1, 8'd254);
      add(0, 4'b0000, 1, 4'b0000, 0, 1, 1, 8'd254); // drained, values retained
      add(1, 4'b1111, 1, 4'b0000, 0, 1, 1, 8'd254); // reset: no grant while high
      add(0, 4'b1111, 1, 4'b0000, 0, 1, 0, 8'd0);
      add(0, 4'b1111, 1, 4'b0001, 0, 1, 0, 8'd0);   // round robin 0,1,2,3,0
      add(0, 4'b1111, 1, 4'b0000, 1, 1, 0, 8'd127);
      add(0, 4'b1111, 1, 4'b0010, 0, 1, 0, 8'd127);
      add(0, 4'b1111, 1, 4'b0000, 1, 1, 1, 8'd254);
      add(0, 4'b1111, 1, 4'b0100, 0, 0, 0, 8'd0);
      add(0, 4'b1111, 1, 4'b0000, 1, 1, 2, 8'd14);
      add(0, 4'b1111, 1, 4'b1000, 0, 0, 0, 8'd0);
      add(0, 4'b1111, 1, 4'b0000, 1, 1, 3, 8'd63);
      add(0, 4'b1111, 1, 4'b0001, 0, 0, 0, 8'd0);
      add(0, 4'b1111, 0, 4'b0000, 1, 1, 0, 8'd127); // backpressure, 5 cycles
      add(0, 4'b1111, 0, 4'b0000, 1, 1, 0, 8'd127); // tick lost
      add(0, 4'b1111, 0, 4'b0000, 1, 1, 0, 8'd127);
      add(0, 4'b1111, 0, 4'b0000, 1, 1, 0, 8'd127); // tick lost
      add(0, 4'b1111, 0, 4'b0000, 1, 1, 0, 8'd127);
      add(0, 4'b1111, 1, 4'b0010, 1, 1, 0, 8'd127); // drain + refill on tick
      add(0, 4'b1111, 1, 4'b0000, 1, 1, 1, 8'd254);
      add(0, 4'b1111, 1, 4'b0100, 0, 0, 0, 8'd0);   // grant 2
      add(0, 4'b1111, 0, 4'b0000, 1, 1, 2, 8'd14);  // hold
      add(0, 4'b1111, 0, 4'b0000, 1, 1, 2, 8'd14);
      add(1, 4'b1111, 0, 4'b0000, 1, 1, 2, 8'd14);  // reset mid-hold
      add(0, 4'b1111, 1, 4'b0000, 0, 1, 0, 8'd0);   // held result discarded
      add(0, 4'b1111, 1, 4'b0001, 0, 0, 0, 8'd0);   // requester 0 wins after reset
      add(0, 4'b0000, 1, 4'b0000, 1, 1, 0, 8'd127);
      add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 8'd0);

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i]);

      // Hand sequence: requester 3 withdraws before the tick and is never granted.
      hv.rst = 1'b0; hv.rdy = 1'b1; hv.exp_rdy = '0; hv.exp_v = 1'b0;
      hv.chk = 1'b1; hv.exp_id = 2'd0; hv.exp_sum = 8'd127;
      hv.valid = 4'b1000; apply(hv);   // no tick
      hv.valid = 4'b0000; apply(hv);   // tick, nothing valid
      apply(hv);                       // still idle, old values retained

      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one registered adder (A+B, result width DATA_W+1) between NUM_REQ requesters.
- Replaces the derived-clock scheme with a single-clock issue strobe, one strobe every DIV cycles.
- Uses round-robin arbitration, a valid/ready request interface per requester and one valid/ready response port tagged with the requester ID.
- Sits between the pin-level input muxing and uo_out in the top-level wrapper.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 7: operand width. Sum width is DATA_W+1, so the default gives 8 bits, matching uo_out.
- DIV, 2: issue-strobe period in clk cycles, >=1. DIV=1 means a strobe every cycle.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*DATA_W  packed operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  packed operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_id  out  clog2(NUM_REQ)  index of the requester that owns the result.
- rsp_sum  out  DATA_W+1  zero-extended A+B.
- busy  out  1  high while a result is held, i.e. rsp_valid.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. All state updates on the rising edge of clk only.
- Reset values: div_cnt=0, rr_ptr=NUM_REQ-1 (requester 0 has first priority), rsp_valid=0, rsp_id=0, rsp_sum=0. req_ready=0 during reset.
- Strobe:
  - div_cnt counts 0..DIV-1 and wraps; it free-runs, independent of traffic.
  - tick=1 when div_cnt==DIV-1. With DIV=1, tick is constantly 1.
- Slot free: slot_free = !rsp_valid || rsp_ready. The same-cycle drain-and-refill case is allowed.
- Grant, combinational:
  - When tick && slot_free && |req_valid, grant the first set req_valid bit searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - req_ready is the one-hot grant; it is 0 otherwise.
  - req_ready never depends on anything except req_valid, tick, rsp_valid, rsp_ready and state (no loop through the sum).
- Accept at edge T (grant i):
  - rsp_sum <= {1'b0,a_i}+{1'b0,b_i}, computed at full width with no truncation.
  - rsp_id <= i, rsp_valid <= 1, rr_ptr <= i.
- Latency: the result is visible the cycle after the accept (1 clk).
- Hold:
  - While rsp_valid && !rsp_ready, rsp_sum and rsp_id are stable and no grants are issued.
  - A tick that occurs during the hold is lost; there is no queuing of ticks.
- Drain without refill: if rsp_valid && rsp_ready and there is no grant this cycle, then rsp_valid <= 0. rsp_sum and rsp_id retain their last values.
- Requester rules:
  - Requesters must hold req_valid and operands stable until req_ready.
  - Deasserting req_valid before grant is allowed; the request is simply not granted.
- Fairness: any continuously valid requester is granted within NUM_REQ accepted transactions.
- rr_ptr changes only on grant.
- Reset mid-operation: a held result is discarded (rsp_valid=0 next cycle) and div_cnt restarts at 0. No partial handshake survives reset.
- Overflow: none is possible, since the sum is DATA_W+1 bits (max 127+127=254 at the default).

Decomposition:
- Shared package adder_arb_pkg:
  - ID_W = clog2(NUM_REQ) helper function.
  - SUM_W = DATA_W+1.
  - Default parameter constants.
- Sub-module rr_arbiter holds the grant logic and the rr_ptr register:
  - Parameter N.
  - Inputs: req[N], en, ptr_upd.
  - Outputs: gnt[N] one-hot, gnt_idx.
- The adder, result register and divider stay in adder_share_arbiter.

Test Plan:
- Reset then idle: rst high 3 cycles with all req_valid=0 -> req_ready=0, rsp_valid=0, rsp_sum=0, busy=0 throughout. div_cnt ticks on cycles 1, 3, 5… after release (DIV=2).
- Single request: req0 a=100, b=27, valid before a tick, rsp_ready=1 -> req_ready=0001 on the tick cycle. Next cycle: rsp_valid=1, rsp_id=0, rsp_sum=127.
- Max operands: a=127, b=127 -> rsp_sum=254 (8'hFE), no wrap.
- Round-robin: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0 on successive ticks, one grant per 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after the first result -> rsp_sum and rsp_id stable and req_ready=0 during the stall. On rsp_ready=1 coinciding with a tick: drain and new grant in the same cycle, and rsp_valid stays 1 with the new sum.
- Reset mid-hold: result held with rsp_ready=0, then assert rst one cycle -> rsp_valid=0 next cycle. After release, requester 0 wins first even if requester 2 was last granted.
